image_writeback: RTL

//  Write-back engine for the downscale datapath: copies the DST_H x DST_W result array into an output ImageMemory in row-major order.
//  It then serves host (JTAG-style) reads of that memory. It sits after Downscale_Secuencial, opposite the source-image load FSM.

---
 rtl/image_writeback_pkg.sv | 27 ++
 rtl/image_writeback_wb_addr_gen.sv | 69 ++++++
 rtl/image_writeback.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/image_writeback_pkg.sv
// image_pkg: shared types and helpers for the image write-back engine.
//   pixel_t       8-bit pixel
//   wb_state_t    write-back FSM states (S_IDLE, S_WRITE, S_DONE)
//   wb_num_pixels number of pixels in a DST_H x DST_W image
//   wb_idx_width  counter width for an index range of n values (minimum 1 bit)
package image_pkg;

   typedef logic [7:0] pixel_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2
   } wb_state_t;

   localparam int unsigned WB_DEF_W = 32'd16;
   localparam int unsigned WB_DEF_H = 32'd16;

   function automatic int unsigned wb_num_pixels(input int unsigned w, input int unsigned h);
      return w * h;
   endfunction

   function automatic int unsigned wb_idx_width(input int unsigned n);
      return (n > 32'd1) ? $clog2(n) : 32'd1;
   endfunction

endpackage

// File: rtl/image_writeback_wb_addr_gen.sv
// wb_addr_gen: row/column scan counters for the write-back pass.
//   clk      clock (posedge)
//   rst      synchronous active-low reset
//   clear    restart the scan at pixel (0,0), address BASE_ADDR
//   advance  step to the next pixel in row-major order
//   row/col  current pixel coordinates
//   addr     current output address (BASE_ADDR + row*DST_W + col, truncated to ADDR_W)
//   last     current pixel is (DST_H-1, DST_W-1)
// The linear address is kept as its own incrementing counter so no multiplier is needed.
module wb_addr_gen
   import image_pkg::*;
#(
   parameter int DST_W     = 16,
   parameter int DST_H     = 16,
   parameter int BASE_ADDR = 0,
   parameter int ADDR_W    = 16,
   parameter int ROW_W     = 4,
   parameter int COL_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              advance,
   output logic [ROW_W-1:0]  row,
   output logic [COL_W-1:0]  col,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(DST_H - 1);
   localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(DST_W - 1);
   localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);

   logic [ROW_W-1:0]  row_r;
   logic [COL_W-1:0]  col_r;
   logic [ADDR_W-1:0] addr_r;

   // Row-major scan counters; column wraps into the next row.
   always_ff @(posedge clk) begin
      if (!rst) begin
         row_r  <= {ROW_W{1'b0}};
         col_r  <= {COL_W{1'b0}};
         addr_r <= ADDR_BASE;
      end else if (clear) begin
         row_r  <= {ROW_W{1'b0}};
         col_r  <= {COL_W{1'b0}};
         addr_r <= ADDR_BASE;
      end else if (advance) begin
         if (col_r == COL_MAX) begin
            col_r <= {COL_W{1'b0}};
            row_r <= (row_r == ROW_MAX) ? {ROW_W{1'b0}} : row_r + {{(ROW_W-1){1'b0}}, 1'b1};
         end else begin
            col_r <= col_r + {{(COL_W-1){1'b0}}, 1'b1};
            row_r <= row_r;
         end
         addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
         row_r  <= row_r;
         col_r  <= col_r;
         addr_r <= addr_r;
      end
   end

   assign row  = row_r;
   assign col  = col_r;
   assign addr = addr_r;
   assign last = (row_r == ROW_MAX) && (col_r == COL_MAX);

endmodule

// File: rtl/image_writeback.sv
// image_writeback: copies the DST_H x DST_W result array into the output
// ImageMemory in row-major order, then serves host reads of that memory.
// Ports:
//   clk          clock (posedge)
//   rst          synchronous active-low reset
//   start        level request, sampled in S_IDLE; must drop before a restart
//   image_out    result array, stable while busy
//   mem_we/mem_addr/mem_wr_data  registered memory write / read-address port
//   mem_rd_data  memory read data (1-cycle synchronous read)
//   rd_req/rd_addr  host read request (accepted in S_IDLE and S_DONE only)
//   rd_data/rd_valid host read response, two cycles after rd_req
//   busy         high in S_WRITE
//   done         high in S_DONE
//   checksum     16-bit pixel sum when built with WB_CHECKSUM_EN, else 0
// Optional feature macro: WB_CHECKSUM_EN (checksum accumulator).
module image_writeback
   import image_pkg::*;
#(
   parameter int DST_W     = 16,
   parameter int DST_H     = 16,
   parameter int BASE_ADDR = 0,
   parameter int ADDR_W    = 16
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [DST_H-1:0][DST_W-1:0][7:0]    image_out,
   output logic                                mem_we,
   output logic [ADDR_W-1:0]                   mem_addr,
   output logic [7:0]                          mem_wr_data,
   input  logic [7:0]                          mem_rd_data,
   input  logic                                rd_req,
   input  logic [ADDR_W-1:0]                   rd_addr,
   output logic [7:0]                          rd_data,
   output logic                                rd_valid,
   output logic                                busy,
   output logic                                done,
   output logic [15:0]                         checksum
);

   localparam int ROW_W = int'(wb_idx_width(DST_H));
   localparam int COL_W = int'(wb_idx_width(DST_W));

   wb_state_t         state_r;
   wb_state_t         state_s;
   logic              last_issued_r;
   logic              issue_s;
   logic              gen_clear_s;
   logic              rd_accept_s;
   logic              last_s;
   logic [ROW_W-1:0]  row_s;
   logic [COL_W-1:0]  col_s;
   logic [ADDR_W-1:0] gen_addr_s;
   pixel_t            pix_s;

   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   pixel_t            mem_wr_data_r;
   logic              rd_pipe_r;
   logic              rd_valid_r;
   logic              busy_r;
   logic              done_r;

   wb_addr_gen #(
      .DST_W     (DST_W),
      .DST_H     (DST_H),
      .BASE_ADDR (BASE_ADDR),
      .ADDR_W    (ADDR_W),
      .ROW_W     (ROW_W),
      .COL_W     (COL_W)
   ) u_addr_gen (
      .clk     (clk),
      .rst     (rst),
      .clear   (gen_clear_s),
      .advance (issue_s),
      .row     (row_s),
      .col     (col_s),
      .addr    (gen_addr_s),
      .last    (last_s)
   );

   assign pix_s = image_out[row_s][col_s];

   // FSM next state and datapath strobes.
   // S_WRITE spends one extra cycle after the last pixel issues so that done
   // follows the last write by one cycle. start wins over a same-cycle read in S_IDLE.
   always_comb begin
      state_s     = state_r;
      issue_s     = 1'b0;
      gen_clear_s = 1'b0;
      rd_accept_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_s     = S_WRITE;
               gen_clear_s = 1'b1;
            end else begin
               state_s     = S_IDLE;
               rd_accept_s = rd_req;
            end
         end
         S_WRITE: begin
            if (last_issued_r) begin
               state_s = S_DONE;
            end else begin
               state_s = S_WRITE;
               issue_s = 1'b1;
            end
         end
         S_DONE: begin
            rd_accept_s = rd_req;
            if (!start) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_DONE;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // FSM state register and end-of-scan flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r       <= S_IDLE;
         last_issued_r <= 1'b0;
      end else begin
         state_r <= state_s;
         if (gen_clear_s) begin
            last_issued_r <= 1'b0;
         end else if (issue_s && last_s) begin
            last_issued_r <= 1'b1;
         end else begin
            last_issued_r <= last_issued_r;
         end
      end
   end

   // Memory port mux (write pass or host read address), read pipe and status.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_we_r      <= 1'b0;
         mem_addr_r    <= {ADDR_W{1'b0}};
         mem_wr_data_r <= 8'h00;
         rd_pipe_r     <= 1'b0;
         rd_valid_r    <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         if (issue_s) begin
            mem_we_r      <= 1'b1;
            mem_addr_r    <= gen_addr_s;
            mem_wr_data_r <= pix_s;
         end else if (rd_accept_s) begin
            mem_we_r      <= 1'b0;
            mem_addr_r    <= rd_addr;
            mem_wr_data_r <= mem_wr_data_r;
         end else begin
            mem_we_r      <= 1'b0;
            mem_addr_r    <= mem_addr_r;
            mem_wr_data_r <= mem_wr_data_r;
         end
         rd_pipe_r  <= rd_accept_s;
         rd_valid_r <= rd_pipe_r;
         busy_r     <= (state_s == S_WRITE);
         done_r     <= (state_s == S_DONE);
      end
   end

`ifdef WB_CHECKSUM_EN
   logic [15:0] checksum_r;

   // Pixel sum, cleared on entry to S_WRITE, frozen outside the write pass.
   always_ff @(posedge clk) begin
      if (!rst) begin
         checksum_r <= 16'h0000;
      end else if (gen_clear_s) begin
         checksum_r <= 16'h0000;
      end else if (issue_s) begin
         checksum_r <= checksum_r + {8'h00, pix_s};
      end else begin
         checksum_r <= checksum_r;
      end
   end

   assign checksum = checksum_r;
`else
   assign checksum = 16'h0000;
`endif

   assign mem_we      = mem_we_r;
   assign mem_addr    = mem_addr_r;
   assign mem_wr_data = mem_wr_data_r;
   assign rd_data     = mem_rd_data;
   assign rd_valid    = rd_valid_r;
   assign busy        = busy_r;
   assign done        = done_r;

endmodule
